// File: rtl/vsm_pkg.sv
// vsm_pkg: driver FSM states, default geometry constants and counter width helper
package vsm_pkg;
  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, HOLD} vsm_state_t;
  localparam int SIZE_DEF = 6;
  localparam int WIDTH_DEF = 8;
  localparam int ACCUMULATIONS_DEF = 3;
  localparam int DRAIN_CYCLES_DEF = 2;
  function automatic int cnt_w(input int a, input int d);
    return $clog2((a > d ? a : d) + 1);
  endfunction
endpackage

// File: rtl/mod_counter.sv
// mod_counter: counts inc pulses 0..TERM, done at TERM, returns to 0 on inc at TERM, sync clear
module mod_counter #(
  parameter int W = 2,
  parameter int TERM = 2
) (
  input  logic clk,
  input  logic clear,
  input  logic inc,
  output logic done
);
  logic [W-1:0] count;
  assign done = count == W'(TERM);
  always_ff @(posedge clk) begin
    if (clear) count <= '0;
    else if (inc) count <= done ? '0 : count + 1'b1;
  end
endmodule

// File: rtl/vsm_driver.sv
// vsm_driver: feeds ACCUMULATIONS handshaken beats (in_*) to a vector-scalar engine (vsm_*), waits DRAIN_CYCLES, then offers the result (res_*)
module vsm_driver
  import vsm_pkg::*;
#(
  parameter int SIZE = SIZE_DEF,
  parameter int WIDTH = WIDTH_DEF,
  parameter int ACCUMULATIONS = ACCUMULATIONS_DEF,
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH*SIZE-1:0]   in_col,
  input  logic [WIDTH-1:0]        in_scalar,
  output logic                    vsm_clear,
  output logic                    vsm_en,
  output logic [WIDTH*SIZE-1:0]   vsm_a,
  output logic [WIDTH-1:0]        vsm_b,
  input  logic [WIDTH*SIZE-1:0]   vsm_out,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [WIDTH*SIZE-1:0]   res_data,
  output logic                    busy
);
  localparam int CW = cnt_w(ACCUMULATIONS, DRAIN_CYCLES);
  vsm_state_t state;
  logic hs, beat_done, drain_done;
  assign in_ready = state == FEED;
  assign busy = state != IDLE;
  assign hs = in_valid && in_ready;
  mod_counter #(.W(CW), .TERM(ACCUMULATIONS - 1)) u_beat (
    .clk(clk), .clear(reset), .inc(hs), .done(beat_done)
  );
  mod_counter #(.W(CW), .TERM(DRAIN_CYCLES - 1)) u_drain (
    .clk(clk), .clear(reset), .inc(state == DRAIN), .done(drain_done)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      vsm_clear <= 1'b1;
      vsm_en <= 1'b0;
      vsm_a <= '0;
      vsm_b <= '0;
      res_valid <= 1'b0;
      res_data <= '0;
    end else begin
      vsm_clear <= state == IDLE && in_valid;
      vsm_en <= hs;
      if (hs) begin
        vsm_a <= in_col;
        vsm_b <= in_scalar;
      end
      case (state)
        IDLE: if (in_valid) state <= CLEAR;
        CLEAR: state <= FEED;
        FEED: if (hs && beat_done) state <= DRAIN;
        DRAIN: if (drain_done) begin
          state <= HOLD;
          res_valid <= 1'b1;
          res_data <= vsm_out;
        end
        HOLD: if (res_ready) begin
          state <= IDLE;
          res_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/vsm_driver.md
VSM_DRIVER -- requirements
Module: vsm_driver

Interface
REQ-001 SHALL have parameter SIZE, default 6, meaning vector lanes.
REQ-002 SHALL have parameter WIDTH, default 8, meaning bits per lane and per scalar.
REQ-003 SHALL have parameter ACCUMULATIONS, default 3, meaning handshaken beats per job.
REQ-004 SHALL have parameter DRAIN_CYCLES, default 2, meaning wait cycles between the last engine enable and result capture.
REQ-005 SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port in_valid, input, 1, upstream beat valid.
REQ-008 SHALL have port in_ready, output, 1, beat accepted when in_valid and in_ready are both 1.
REQ-009 SHALL have port in_col, input, WIDTH*SIZE, column vector for the beat.
REQ-010 SHALL have port in_scalar, input, WIDTH, scalar for the beat.
REQ-011 SHALL have port vsm_clear, output, 1, engine clear pulse.
REQ-012 SHALL have port vsm_en, output, 1, engine enable.
REQ-013 SHALL have port vsm_a, output, WIDTH*SIZE, engine vector operand.
REQ-014 SHALL have port vsm_b, output, WIDTH, engine scalar operand.
REQ-015 SHALL have port vsm_out, input, WIDTH*SIZE, engine result.
REQ-016 SHALL have port res_valid, output, 1, result available.
REQ-017 SHALL have port res_ready, input, 1, downstream accepts result.
REQ-018 SHALL have port res_data, output, WIDTH*SIZE, captured result.
REQ-019 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-020 SHALL implement states IDLE, CLEAR, FEED, DRAIN, HOLD.
REQ-021 IDLE SHALL move to CLEAR when in_valid=1; in_ready=0 in IDLE.
REQ-022 CLEAR SHALL last exactly one cycle with vsm_clear=1, then move to FEED; vsm_clear=0 in every other non-reset cycle.
REQ-023 FEED SHALL assert in_ready=1; in_ready SHALL be 0 in all other states.
REQ-024 Each FEED handshake in cycle t SHALL register vsm_a=in_col and vsm_b=in_scalar and drive vsm_en=1 in cycle t+1 only.
REQ-025 A FEED cycle without a handshake (bubble) SHALL produce vsm_en=0 next cycle; vsm_a and vsm_b SHALL hold their values.
REQ-026 The beat counter SHALL count 0..ACCUMULATIONS-1; the handshake at count ACCUMULATIONS-1 SHALL move to DRAIN and clear the counter.
REQ-027 DRAIN SHALL count DRAIN_CYCLES cycles after the last vsm_en cycle, then load res_data=vsm_out, set res_valid=1, and move to HOLD.
REQ-028 HOLD SHALL keep res_valid and res_data stable until res_ready=1; on that cycle the block SHALL clear res_valid next cycle and return to IDLE.
REQ-029 A res_ready asserted while res_valid=0 SHALL be ignored.
REQ-030 No new beat SHALL be accepted from the last FEED handshake until IDLE is re-entered; back-to-back jobs cost 1 IDLE + 1 CLEAR cycle.
REQ-031 Counters SHALL be $clog2(max(ACCUMULATIONS,DRAIN_CYCLES)+1) bits and SHALL never wrap.

Reset
REQ-032 While reset=1 the block SHALL set state IDLE, counters 0, in_ready=0, vsm_en=0, res_valid=0, busy=0, vsm_a=0, vsm_b=0, res_data=0.
REQ-033 While reset=1 the block SHALL hold vsm_clear=1 so the engine is cleared with it.
REQ-034 Reset in any state, including mid-FEED or HOLD, SHALL abandon the job with no result emitted and no beat counted.

Structure
REQ-035 The state enum and default parameter constants SHALL reside in the shared package vsm_pkg.
REQ-036 Beat and drain counting SHALL use one sub-module, mod_counter (parameterised terminal count, inc, clear, done), instantiated twice.

Verification
REQ-037 Basic: reset, then 3 beats back-to-back (col lanes=1..6, scalar=2) -> vsm_clear 1 cycle, vsm_en high 3 consecutive cycles, res_valid 2 cycles after the last enable, res_data=vsm_out at capture.
REQ-038 Bubbles: beats with in_valid gaps of 2 cycles -> vsm_en exactly 3 pulses, each one cycle after its handshake; operands held across gaps.
REQ-039 Backpressure: res_ready low 5 cycles -> res_valid and res_data stable 5 cycles; in_ready=0 throughout.
REQ-040 Mid-job reset: reset after beat 2 -> all outputs 0, vsm_clear=1 during reset; next job of 3 beats yields correct res_data.
REQ-041 Back-to-back jobs: in_valid held high, res_ready=1 -> second job CLEAR starts 2 cycles after result handshake; two results, none lost.
